// File: rtl/ll_fifo_pkg.sv
// ll_fifo_pkg
// Shared types and constants for the linked-list FIFO read-side drain logic.
// Contents:
//   DEFAULT_WIDTH / DEFAULT_NUM_FIFOS / DEFAULT_SEL_WIDTH : default configuration
//   SKID_DEPTH    : entries in the output skid buffer
//   sel_t         : queue-select type for the default configuration
//   drain_state_e : drain sequencer states (RUN, FLUSH, DONE)
//   skid_entry_t  : skid buffer entry {data, sel} for the default configuration
//   sel_width()   : select width for a given queue count (minimum 1 bit)
package ll_fifo_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_NUM_FIFOS = 2;
  localparam int DEFAULT_SEL_WIDTH = (DEFAULT_NUM_FIFOS > 1) ? $clog2(DEFAULT_NUM_FIFOS) : 1;
  localparam int SKID_DEPTH        = 2;

  typedef logic [DEFAULT_SEL_WIDTH-1:0] sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
    sel_t                     sel;
  } skid_entry_t;

  // A single queue still needs a one-bit select so ports never collapse to zero width.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ll_fifo_drain_arbiter_skid.sv
// ll_drain_skid
// Two-entry skid buffer between the pop side of the shared queue and the
// downstream valid/ready stream. Entries are opaque {data, sel} words.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the buffer)
//   wr_en     : write wr_entry at the tail this cycle (caller guarantees space)
//   wr_entry  : entry to write
//   valid     : head entry present (occ != 0)
//   ready     : downstream accepts the head entry this cycle
//   rd_entry  : head entry
//   occ       : current occupancy, 0..2
module ll_drain_skid
  import ll_fifo_pkg::*;
#(
  parameter int ENTRY_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_entry,
  output logic               valid,
  input  logic               ready,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic [1:0]         occ
);

  logic [ENTRY_W-1:0] mem [SKID_DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         occ_q;
  logic               rd_en;

  assign valid    = (occ_q != 2'd0);
  assign rd_en    = valid & ready;
  assign rd_entry = mem[rd_ptr];
  assign occ      = occ_q;

  // Storage carries no reset; occupancy alone decides what is visible.
  // A write while full is only issued together with a read, so the slot
  // overwritten is the one leaving this cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and occupancy; simultaneous write and read leave occ unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (wr_en) begin
        wr_ptr <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      occ_q <= occ_q + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

endmodule

// File: rtl/ll_fifo_drain_arbiter.sv
// ll_fifo_drain_arbiter
// Read-side master for linked_list_fifo. Pops non-empty queues round-robin,
// captures head data into a 2-entry skid buffer and streams it downstream
// tagged with its source queue. A flush sequencer drains every queue on request.
// Configuration macro: LL_DRAIN_STRICT_PRIO_EN
//   defined   : queue 0 has strict priority, remaining queues round-robin
//   undefined : pure round-robin over all queues
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   en           : permits pops while in RUN
//   flush        : single-cycle request to drain all queues
//   ll_empty     : per-queue empty flags from linked_list_fifo
//   ll_data_out  : head data of queue ll_pop_sel (combinational from the fifo)
//   ll_pop       : pop strobe to linked_list_fifo
//   ll_pop_sel   : queue being popped
//   m_valid/m_ready/m_data/m_sel : downstream stream, m_sel = source queue
//   flush_done   : one-cycle pulse when a flush completes
//   pop_count    : total pops since reset, wrapping
module ll_fifo_drain_arbiter
  import ll_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = sel_width(NUM_FIFOS),
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic [NUM_FIFOS-1:0] ll_empty,
  input  logic [WIDTH-1:0]     ll_data_out,
  output logic                 ll_pop,
  output logic [SEL_WIDTH-1:0] ll_pop_sel,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [SEL_WIDTH-1:0] m_sel,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] pop_count
);

  typedef struct packed {
    logic [WIDTH-1:0]     data;
    logic [SEL_WIDTH-1:0] sel;
  } entry_t;

  localparam int ENTRY_W = WIDTH + SEL_WIDTH;

  drain_state_e         state_q;
  drain_state_e         state_d;
  logic [SEL_WIDTH-1:0] rr_last_q;
  logic [SEL_WIDTH-1:0] grant;
  logic [SEL_WIDTH-1:0] cand;
  logic                 found;
  logic                 space;
  logic                 allowed;
  logic [1:0]           occ;
  logic [CNT_WIDTH-1:0] pop_count_q;
  entry_t               wr_entry;
  entry_t               rd_entry;

  // A pop is allowed only when the skid can take the word this cycle, which
  // includes the full case where the head is leaving downstream at the same time.
  assign space      = (occ < 2'd2) | (m_valid & m_ready);
  assign allowed    = space & ((state_q == FLUSH) | en);
  assign ll_pop     = allowed & found;
  assign ll_pop_sel = grant;
  assign pop_count  = pop_count_q;

  assign wr_entry.data = ll_data_out;
  assign wr_entry.sel  = grant;
  assign m_data        = rd_entry.data;
  assign m_sel         = rd_entry.sel;

  // Round-robin search starting just after the last served queue. With strict
  // priority, a non-empty queue 0 overrides the search; when queue 0 is empty
  // the same search naturally rotates among the others.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_FIFOS; i++) begin
      cand = SEL_WIDTH'((int'(rr_last_q) + i) % NUM_FIFOS);
      if (!found && !ll_empty[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
`ifdef LL_DRAIN_STRICT_PRIO_EN
    if (!ll_empty[0]) begin
      grant = '0;
    end
`endif
  end

  // Flush sequencer: FLUSH ends only at global empty with nothing buffered or
  // being popped, so pushes arriving mid-flush are drained as well.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if ((&ll_empty) && (occ == 2'd0) && !ll_pop) begin
          state_d = DONE;
        end
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, round-robin pointer and pop counter. Resetting rr_last to the last
  // queue makes queue 0 the first one served.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      rr_last_q   <= SEL_WIDTH'(NUM_FIFOS - 1);
      pop_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (ll_pop) begin
        pop_count_q <= pop_count_q + CNT_WIDTH'(1);
`ifdef LL_DRAIN_STRICT_PRIO_EN
        if (grant != '0) begin
          rr_last_q <= grant;
        end
`else
        rr_last_q <= grant;
`endif
      end
    end
  end

  ll_drain_skid #(
    .ENTRY_W (ENTRY_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (ll_pop),
    .wr_entry (wr_entry),
    .valid    (m_valid),
    .ready    (m_ready),
    .rd_entry (rd_entry),
    .occ      (occ)
  );

endmodule

// File: tb/tb_ll_fifo_drain_arbiter.sv
// tb_ll_fifo_drain_arbiter
// Self-checking bench for ll_fifo_drain_arbiter (WIDTH=8, NUM_FIFOS=2).
// A small two-queue fifo model answers pops with combinational head data;
// stimulus pushes expected {sel,data} words into a scoreboard queue and an
// independent monitor compares every accepted downstream word.
// Honors LL_DRAIN_STRICT_PRIO_EN for the expected arbitration order.
module tb_ll_fifo_drain_arbiter;

  localparam int WIDTH     = 8;
  localparam int NUM_FIFOS = 2;
  localparam int SEL_WIDTH = 1;
  localparam int CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 flush;
  logic [NUM_FIFOS-1:0] ll_empty;
  logic [WIDTH-1:0]     ll_data_out;
  logic                 ll_pop;
  logic [SEL_WIDTH-1:0] ll_pop_sel;
  logic                 m_valid;
  logic                 m_ready;
  logic [WIDTH-1:0]     m_data;
  logic [SEL_WIDTH-1:0] m_sel;
  logic                 flush_done;
  logic [CNT_WIDTH-1:0] pop_count;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] head0;
  logic [7:0] head1;
  logic [8:0] exp_q [$];
  logic [8:0] mon_exp;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign ll_data_out = ll_pop_sel ? head1 : head0;

  ll_fifo_drain_arbiter #(
    .WIDTH     (WIDTH),
    .NUM_FIFOS (NUM_FIFOS),
    .SEL_WIDTH (SEL_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .flush       (flush),
    .ll_empty    (ll_empty),
    .ll_data_out (ll_data_out),
    .ll_pop      (ll_pop),
    .ll_pop_sel  (ll_pop_sel),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_sel       (m_sel),
    .flush_done  (flush_done),
    .pop_count   (pop_count)
  );

  // Monitor: every accepted downstream word must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL stream: got sel=%0d data=%h, required no output", m_sel, m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({m_sel, m_data} !== mon_exp) begin
          mismatched++;
          $display("[TB] FAIL stream: got sel=%0d data=%h, required sel=%0d data=%h",
                   m_sel, m_data, mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  // Global time limit so a stuck design still ends with a report.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void refreshModel();
    ll_empty = {q1.size() == 0, q0.size() == 0};
    head0    = (q0.size() != 0) ? q0[0] : 8'h00;
    head1    = (q1.size() != 0) ? q1[0] : 8'h00;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One clock: sample the pop request before the edge, apply it to the model after.
  task automatic tick();
    logic p;
    logic s;
    @(negedge clk);
    p = ll_pop;
    s = ll_pop_sel;
    @(posedge clk);
    #2;
    if (p) begin
      compared++;
      if ((s == 1'b0 && q0.size() == 0) || (s == 1'b1 && q1.size() == 0)) begin
        mismatched++;
        $display("[TB] FAIL pop_empty: got pop of queue %0d, required non-empty queue", s);
      end else if (s == 1'b0) begin
        void'(q0.pop_front());
      end else begin
        void'(q1.pop_front());
      end
    end
    refreshModel();
  endtask

  task automatic applyStimulus(input int q, input logic [7:0] d);
    if (q == 0) q0.push_back(d);
    else        q1.push_back(d);
    refreshModel();
  endtask

  task automatic expectWord(input logic s, input logic [7:0] d);
    exp_q.push_back({s, d});
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic resetDut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Returns the cycle offset of flush_done from the pulse cycle, or 99 on timeout.
  task automatic waitFlushDone(output int offset);
    int n = 1;
    offset = 99;
    while (n < 30) begin
      if (flush_done) begin
        offset = n;
        break;
      end
      tick();
      n++;
    end
  endtask

  initial begin
    int off;
    int seen;
    rst     = 1'b1;
    en      = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    refreshModel();
    resetDut();

    $display("[TB] reset state");
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_ll_pop", 32'(ll_pop), 32'd0);
    checkOutput("rst_flush_done", 32'(flush_done), 32'd0);
    checkOutput("rst_pop_count", 32'(pop_count), 32'd0);

    $display("[TB] test 1: mixed queues");
    applyStimulus(0, 8'hA1);
    applyStimulus(1, 8'hB2);
    applyStimulus(0, 8'hA3);
`ifdef LL_DRAIN_STRICT_PRIO_EN
    expectWord(1'b0, 8'hA1);
    expectWord(1'b0, 8'hA3);
    expectWord(1'b1, 8'hB2);
`else
    expectWord(1'b0, 8'hA1);
    expectWord(1'b1, 8'hB2);
    expectWord(1'b0, 8'hA3);
`endif
    en      = 1'b1;
    m_ready = 1'b1;
    waitDrain(20);
    checkOutput("t1_pop_count", 32'(pop_count), 32'd3);
    en = 1'b0;

    $display("[TB] test 2: backpressure");
    m_ready = 1'b0;
    applyStimulus(0, 8'hC0);
    applyStimulus(0, 8'hC1);
    applyStimulus(0, 8'hC2);
    applyStimulus(0, 8'hC3);
    expectWord(1'b0, 8'hC0);
    expectWord(1'b0, 8'hC1);
    expectWord(1'b0, 8'hC2);
    expectWord(1'b0, 8'hC3);
    en = 1'b1;
    repeat (5) tick();
    checkOutput("t2_pop_count_held", 32'(pop_count), 32'd5);
    checkOutput("t2_ll_pop_full", 32'(ll_pop), 32'd0);
    checkOutput("t2_m_valid", 32'(m_valid), 32'd1);
    checkOutput("t2_m_data_held", 32'(m_data), 32'hC0);
    tick();
    checkOutput("t2_m_data_still", 32'({m_sel, m_data}), 32'h0C0);
    m_ready = 1'b1;
    waitDrain(20);
    checkOutput("t2_pop_count", 32'(pop_count), 32'd7);
    en = 1'b0;

    $display("[TB] test 3: flush with en low");
    applyStimulus(0, 8'hD0);
    applyStimulus(1, 8'hD1);
`ifdef LL_DRAIN_STRICT_PRIO_EN
    expectWord(1'b0, 8'hD0);
    expectWord(1'b1, 8'hD1);
`else
    expectWord(1'b1, 8'hD1);
    expectWord(1'b0, 8'hD0);
`endif
    pulseFlush();
    waitFlushDone(off);
    checkOutput("t3_flush_done_cycle", 32'(off), 32'd5);
    checkOutput("t3_drained", 32'(exp_q.size()), 32'd0);
    tick();
    checkOutput("t3_flush_done_single", 32'(flush_done), 32'd0);
    applyStimulus(0, 8'hE5);
    repeat (3) tick();
    checkOutput("t3_run_en_gate", 32'(ll_pop), 32'd0);
    expectWord(1'b0, 8'hE5);
    en = 1'b1;
    waitDrain(20);
    checkOutput("t3_pop_count", 32'(pop_count), 32'd10);
    en = 1'b0;

    $display("[TB] test 4: reset during flush");
    m_ready = 1'b0;
    applyStimulus(0, 8'hE0);
    applyStimulus(0, 8'hE1);
    applyStimulus(0, 8'hE2);
    pulseFlush();
    repeat (3) tick();
    checkOutput("t4_m_valid_full", 32'(m_valid), 32'd1);
    checkOutput("t4_ll_pop_full", 32'(ll_pop), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t4_m_valid_reset", 32'(m_valid), 32'd0);
    checkOutput("t4_pop_count_reset", 32'(pop_count), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (flush_done) seen = 1;
      tick();
    end
    checkOutput("t4_no_flush_done", 32'(seen), 32'd0);
    expectWord(1'b0, 8'hE2);
    en      = 1'b1;
    m_ready = 1'b1;
    waitDrain(20);
    checkOutput("t4_pop_count", 32'(pop_count), 32'd1);
    en = 1'b0;

    $display("[TB] test 5: arbitration order");
    resetDut();
    applyStimulus(0, 8'hF0);
    applyStimulus(0, 8'hF1);
    applyStimulus(0, 8'hF2);
    applyStimulus(1, 8'h60);
    applyStimulus(1, 8'h61);
    applyStimulus(1, 8'h62);
`ifdef LL_DRAIN_STRICT_PRIO_EN
    expectWord(1'b0, 8'hF0);
    expectWord(1'b0, 8'hF1);
    expectWord(1'b0, 8'hF2);
    expectWord(1'b1, 8'h60);
    expectWord(1'b1, 8'h61);
    expectWord(1'b1, 8'h62);
`else
    expectWord(1'b0, 8'hF0);
    expectWord(1'b1, 8'h60);
    expectWord(1'b0, 8'hF1);
    expectWord(1'b1, 8'h61);
    expectWord(1'b0, 8'hF2);
    expectWord(1'b1, 8'h62);
`endif
    en      = 1'b1;
    m_ready = 1'b1;
    waitDrain(30);
    checkOutput("t5_pop_count", 32'(pop_count), 32'd6);

    $display("[TB] test 6: pop_count wrap and empty flush");
    resetDut();
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(0, i[7:0]);
      expectWord(1'b0, i[7:0]);
      tick();
    end
    waitDrain(20);
    checkOutput("t6_pop_count_max", 32'(pop_count), 32'hFFFF);
    applyStimulus(0, 8'h5A);
    expectWord(1'b0, 8'h5A);
    waitDrain(20);
    checkOutput("t6_pop_count_wrap", 32'(pop_count), 32'd0);
    en = 1'b0;
    pulseFlush();
    waitFlushDone(off);
    checkOutput("t6_empty_flush_cycle", 32'(off), 32'd2);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
